// File: rtl/mux_arb_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_arb_reg: N-input selector with a one-entry registered output stage,  |
// | direct-select or round-robin arbitration, valid/ready on every port.     |
// | Optional macro MUX_ARB_LOCK_EN adds a `lock` input for burst ownership.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_arb_reg #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef MUX_ARB_LOCK_EN
  input  logic                    lock,
`endif
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  localparam logic [SEL_W:0]   c_num_in_ext = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] c_ptr_rst    = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             w_can_load;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant;
  logic             w_load;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_cand;

  assign w_can_load = !out_valid_q || out_ready;
  assign w_load     = w_grant_vld && w_can_load;

  // Round-robin search walks rr_ptr+1 .. rr_ptr+NUM_IN modulo NUM_IN; first valid wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_sum       = '0;
    w_cand      = '0;
    if (!mode) begin
      if (({1'b0, sel} < c_num_in_ext) && in_valid[sel]) begin
        w_grant_vld = 1'b1;
        w_grant     = sel;
      end
    end else begin
`ifdef MUX_ARB_LOCK_EN
      if (lock && in_valid[rr_ptr_q]) begin
        w_grant_vld = 1'b1;
        w_grant     = rr_ptr_q;
      end
`endif
      for (int k = 1; k <= NUM_IN; k++) begin
        w_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
        if (w_sum >= c_num_in_ext) begin
          w_sum = w_sum - c_num_in_ext;
        end
        w_cand = w_sum[SEL_W-1:0];
        if (!w_grant_vld && in_valid[w_cand]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ready
    assign in_ready[i] = w_load && (w_grant == SEL_W'(i));
  end

  // A load in the same cycle as a drain replaces the item, so no bubble appears.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (w_load) begin
      out_data_d  = w_sel_data;
      out_valid_d = 1'b1;
      out_src_d   = w_grant;
      if (mode) begin
        rr_ptr_d = w_grant;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      rr_ptr_q    <= c_ptr_rst;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule
`default_nettype wire
